// File: rtl/systolic_mm_ctrl_if.sv
// Job, operand-buffer and PE-array signals of the systolic sequencing controller.
// master: the controller; slave: host / buffers / PE array side.
interface systolic_mm_ctrl_if #(
  parameter int N   = 4,
  parameter int K_W = 5
);
  logic             req_i;
  logic [K_W-1:0]   k_i;
  logic             ack_o;
  logic             busy_o;
  logic             rd_en_o;
  logic [K_W-1:0]   rd_addr_o;
  logic [N-1:0]     skew_en_o;
  logic             pe_start_o;
  logic [N*N-1:0]   pe_ovf_i;
  logic             ovf_o;
  logic             done_o;

  modport master (
    input  req_i, k_i, pe_ovf_i,
    output ack_o, busy_o, rd_en_o, rd_addr_o, skew_en_o, pe_start_o, ovf_o, done_o
  );

  modport slave (
    output req_i, k_i, pe_ovf_i,
    input  ack_o, busy_o, rd_en_o, rd_addr_o, skew_en_o, pe_start_o, ovf_o, done_o
  );
endinterface

// File: rtl/systolic_mm_ctrl.sv
// Sequencing controller for an N x N systolic MAC array: clears accumulators,
// streams K operand reads, and drives per-lane skew windows so each row/column
// sees valid data only for t in [r, r+K-1]. All outputs are registered and
// reflect the state entered at the same edge.

// Per-lane skew window: lane R is live while R <= t < R+K.
module systolic_mm_lane #(
  parameter int R   = 0,
  parameter int K_W = 5,
  parameter int T_W = 6
) (
  input  logic [T_W-1:0] t,
  input  logic [K_W-1:0] k,
  output logic           en
);
  localparam logic [T_W:0] LO = (T_W+1)'(R);
  logic [T_W:0] hi;
  logic [T_W:0] t_x;

  // Window compare done one bit wider so R+K never wraps.
  always_comb begin
    t_x = {1'b0, t};
    hi  = LO + (T_W+1)'(k);
    en  = (t_x >= LO) && (t_x < hi);
  end
endmodule

module systolic_mm_ctrl #(
  parameter int N     = 4,
  parameter int MAX_K = 16,
  parameter int K_W   = 5,
  parameter int T_W   = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  systolic_mm_ctrl_if.master    bus
);
  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  state_t         state;
  logic [K_W-1:0] k_q;
  logic [T_W-1:0] t_q;

  logic [K_W-1:0] k_cl;
  logic [T_W-1:0] tl;
  logic [T_W-1:0] t_nx;
  logic           rd_en_nx;
  logic [K_W-1:0] addr_nx;
  logic [N-1:0]   lane_en;

  // Next feed-step values; outputs are computed one step ahead so they can be registered.
  always_comb begin
    k_cl     = (bus.k_i > K_W'(MAX_K)) ? K_W'(MAX_K) : bus.k_i;
    tl       = T_W'(k_q) + T_W'(2*N-3);
    t_nx     = (state == CLEAR) ? '0 : t_q + 1'b1;
    rd_en_nx = t_nx < T_W'(k_q);
    addr_nx  = rd_en_nx ? K_W'(t_nx) : k_q - 1'b1;
  end

  for (genvar r = 0; r < N; r++) begin : g_lane
    systolic_mm_lane #(.R(r), .K_W(K_W), .T_W(T_W)) u_lane (
      .t  (t_nx),
      .k  (k_q),
      .en (lane_en[r])
    );
  end

  // Job FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      k_q            <= '0;
      t_q            <= '0;
      bus.ack_o      <= 1'b0;
      bus.busy_o     <= 1'b0;
      bus.rd_en_o    <= 1'b0;
      bus.rd_addr_o  <= '0;
      bus.skew_en_o  <= '0;
      bus.pe_start_o <= 1'b0;
      bus.ovf_o      <= 1'b0;
      bus.done_o     <= 1'b0;
    end else begin
      bus.ack_o  <= 1'b0;
      bus.done_o <= 1'b0;
      // Overflow is collected only while the array is computing or finishing.
      if (state == FEED || state == DONE)
        bus.ovf_o <= bus.ovf_o | (|bus.pe_ovf_i);
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            k_q            <= k_cl;
            bus.ack_o      <= 1'b1;
            bus.busy_o     <= 1'b1;
            bus.pe_start_o <= 1'b0;
            bus.ovf_o      <= 1'b0;
            bus.skew_en_o  <= '0;
            bus.rd_en_o    <= 1'b0;
            state          <= CLEAR;
          end
        end
        CLEAR: begin
          bus.pe_start_o <= 1'b1;
          if (k_q == '0) begin
            bus.done_o <= 1'b1;
            state      <= DONE;
          end else begin
            t_q           <= '0;
            bus.rd_en_o   <= rd_en_nx;
            bus.rd_addr_o <= addr_nx;
            bus.skew_en_o <= lane_en;
            state         <= FEED;
          end
        end
        FEED: begin
          if (t_q == tl) begin
            bus.done_o    <= 1'b1;
            bus.rd_en_o   <= 1'b0;
            bus.skew_en_o <= '0;
            state         <= DONE;
          end else begin
            t_q           <= t_nx;
            bus.rd_en_o   <= rd_en_nx;
            bus.rd_addr_o <= addr_nx;
            bus.skew_en_o <= lane_en;
          end
        end
        DONE: begin
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// Bench for systolic_mm_ctrl: per-cycle output vectors predicted from the job
// timeline (CLEAR, K+2N-2 feed steps, DONE) and compared with immediate assertions.
module tb_systolic_mm_ctrl;
  localparam int N     = 4;
  localparam int MAX_K = 16;
  localparam int K_W   = 5;
  localparam int T_W   = 6;
  localparam int W     = K_W + N + 6;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  systolic_mm_ctrl_if #(.N(N), .K_W(K_W)) bus ();

  systolic_mm_ctrl #(.N(N), .MAX_K(MAX_K), .K_W(K_W), .T_W(T_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state carried between jobs.
  int last_addr = 0;
  bit started   = 0;
  bit ovf_m     = 0;

  function automatic logic [W-1:0] ev(bit ack, bit busy, bit rd_en, int addr,
                                      logic [N-1:0] sk, bit ps, bit ovf, bit done);
    return {ack, busy, rd_en, K_W'(addr), sk, ps, ovf, done};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] obs;
    obs = {bus.ack_o, bus.busy_o, bus.rd_en_o, bus.rd_addr_o, bus.skew_en_o,
           bus.pe_start_o, bus.ovf_o, bus.done_o};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%b exp=%b (ack busy rd_en addr skew start ovf done)", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk_i);
    check(tag, ev(0, 0, 0, last_addr, '0, started, ovf_m, 0));
  endtask

  // One full job from request to the IDLE cycle after done_o.
  task automatic run_job(input int kin, input bit ovf_en, input int ovf_bit, input bit keep);
    int kk, total, t, addr, ovf_at;
    bit rd_en;
    logic [N-1:0] sk;
    kk     = (kin > MAX_K) ? MAX_K : kin;
    total  = (kk == 0) ? 2 : kk + 2*N;
    ovf_at = (ovf_en && kk > 0) ? $urandom_range(2, total - 1) : 0;
    bus.req_i = 1'b1;
    bus.k_i   = K_W'(kin);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk_i);
      if (!keep) bus.req_i = 1'b0;
      bus.pe_ovf_i = '0;
      if (c == 1) begin
        ovf_m = 0;
        check("clear", ev(1, 1, 0, last_addr, '0, 0, 0, 0));
      end else if (c == total) begin
        check("done", ev(0, 1, 0, last_addr, '0, 1, ovf_m, 1));
      end else begin
        t     = c - 2;
        rd_en = (t < kk);
        addr  = rd_en ? t : kk - 1;
        for (int r = 0; r < N; r++) sk[r] = (t >= r) && (t <= r + kk - 1);
        last_addr = addr;
        check($sformatf("feed_k%0d_t%0d", kk, t), ev(0, 1, rd_en, addr, sk, 1, ovf_m, 0));
      end
      if (c == ovf_at) begin
        bus.pe_ovf_i = (N*N)'(1) << ovf_bit;
        ovf_m = 1;
      end
    end
    started = 1;
    @(negedge clk_i);
    bus.pe_ovf_i = '0;
    check("idle_after_job", ev(0, 0, 0, last_addr, '0, 1, ovf_m, 0));
    if (!keep) bus.req_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    bus.req_i = 1'b0;
    bus.k_i = '0;
    bus.pe_ovf_i = '0;
    repeat (2) @(negedge clk_i);
    check("reset", ev(0, 0, 0, 0, '0, 0, 0, 0));
    rst_i = 1'b0;
    idle_check("idle_post_reset");

    // Directed shapes: short, single-step, empty job.
    run_job(3, 0, 0, 0);  idle_check("gap");
    run_job(1, 0, 0, 0);  idle_check("gap");
    run_job(0, 0, 0, 0);  idle_check("gap");

    // Overflow on PE 5 must stick through DONE/IDLE and clear in next CLEAR.
    run_job($urandom_range(2, MAX_K), 1, 5, 0);
    idle_check("ovf_hold_idle");
    run_job($urandom_range(1, MAX_K), 0, 0, 0);

    // Back-to-back with req held high.
    run_job($urandom_range(0, MAX_K), 0, 0, 1);
    run_job($urandom_range(0, MAX_K), 1, $urandom_range(0, N*N-1), 1);
    run_job($urandom_range(0, MAX_K), 0, 0, 0);
    idle_check("gap");

    // Clamp: k_i beyond MAX_K.
    run_job(31, 0, 0, 0);
    idle_check("gap");

    // Random jobs.
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, N*N-1), 0);
      idle_check("gap_rand");
    end

    // Reset in the middle of FEED aborts without done_o.
    bus.req_i = 1'b1;
    bus.k_i   = K_W'($urandom_range(4, MAX_K));
    repeat (4) @(negedge clk_i);
    bus.req_i = 1'b0;
    bus.pe_ovf_i = '1;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    bus.pe_ovf_i = '0;
    last_addr = 0; started = 0; ovf_m = 0;
    check("reset_mid_feed", ev(0, 0, 0, 0, '0, 0, 0, 0));
    repeat (3) idle_check("idle_after_abort");

    run_job($urandom_range(1, MAX_K), 1, 5, 0);
    idle_check("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
